// File: rtl/wb_bram_burst_pkg.sv
// +--------------------------------------------------------------------+
// | wb_pkg: Wishbone cycle/burst types, slave states, burst next-word. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package wb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    BURST     = 2'd2
  } state_t;

  // Wrapping bursts only advance the low log2(N) bits; linear advances all.
  function automatic logic [31:0] next_word(input logic [31:0] word, input bte_t bte);
    logic [31:0] mask;
    logic [31:0] inc;
    case (bte)
      BTE_WRAP4:  mask = 32'h0000_0003;
      BTE_WRAP8:  mask = 32'h0000_0007;
      BTE_WRAP16: mask = 32'h0000_000F;
      default:    mask = 32'hFFFF_FFFF;
    endcase
    inc = word + 32'd1;
    return (word & ~mask) | (inc & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bram_burst_if.sv
// +--------------------------------------------------------------------+
// | wb_bram_burst_if: Wishbone B4 bus bundle with master/slave views.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface wb_bram_burst_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int c_sel_w = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [31:0]           adr;
  logic [c_sel_w-1:0]    sel;
  logic [DATA_WIDTH-1:0] dat_ms;
  logic [2:0]            cti;
  logic [1:0]            bte;
  logic [DATA_WIDTH-1:0] dat_sm;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

`default_nettype wire

// File: rtl/wb_bram_burst_bram_sp.sv
// +--------------------------------------------------------------------+
// | bram_sp: single-port byte-enabled RAM with registered read port.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bram_sp #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_WIDTH    = 32
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      re,
  input  wire logic [DATA_WIDTH/8-1:0]   we,
  input  wire logic [MEM_ADR_WIDTH-1:0]  addr,
  input  wire logic [DATA_WIDTH-1:0]     wdata,
  output logic      [DATA_WIDTH-1:0]     rdata
);
  localparam int c_sel_w = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**MEM_ADR_WIDTH];

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_sel_w; i++) begin
      if (we[i]) begin
        r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_bram_burst.sv
// +--------------------------------------------------------------------+
// | wb_bram_burst: Wishbone slave over a BRAM with classic/burst reads.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_WIDTH    = 32
) (
  input wire logic        clk,
  input wire logic        rst,
  wb_bram_burst_if.slave  bus
);
  localparam int c_sel_w  = DATA_WIDTH / 8;
  localparam int c_adr_sh = $clog2(c_sel_w);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [31:0]               r_addr;
  bte_t                      r_bte;
  logic                      r_oor;

  logic [31:0]               w_word;
  logic [31:0]               w_next;
  logic                      w_in_range;
  logic                      w_req;
  logic                      w_ack;
  logic                      w_err;
  logic                      w_mem_re;
  logic [c_sel_w-1:0]        w_mem_we;
  logic [MEM_ADR_WIDTH-1:0]  w_mem_addr;
  logic                      w_capture;
  logic                      w_advance;
  logic [DATA_WIDTH-1:0]     w_rdata;

  assign w_word     = bus.adr >> c_adr_sh;
  assign w_in_range = (w_word >> MEM_ADR_WIDTH) == 32'd0;
  assign w_req      = bus.cyc & bus.stb;
  assign w_next     = next_word(r_addr, r_bte);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_addr always names the word currently sitting in the RAM read register.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_addr <= w_word;
      r_bte  <= bte_t'(bus.bte);
      r_oor  <= !w_in_range;
    end else if (w_advance) begin
      r_addr <= w_next;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_we    = '0;
    w_mem_addr  = w_word[MEM_ADR_WIDTH-1:0];
    w_capture   = 1'b0;
    w_advance   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (bus.we) begin
            if (w_in_range) begin
              w_ack    = 1'b1;
              w_mem_we = bus.sel;
            end else begin
              w_err = 1'b1;
            end
          end else begin
            // Out-of-range reads still wait a cycle so err keeps ack's timing.
            w_capture = 1'b1;
            w_mem_re  = w_in_range;
            if (w_in_range && bus.cti == CTI_INCR) begin
              w_state_nxt = BURST;
            end else begin
              w_state_nxt = READ_WAIT;
            end
          end
        end
      end

      READ_WAIT: begin
        if (!bus.cyc) begin
          w_state_nxt = IDLE;
        end else if (bus.stb) begin
          if (r_oor || bus.we) begin
            w_err = 1'b1;
          end else begin
            w_ack = 1'b1;
          end
          w_state_nxt = IDLE;
        end
      end

      BURST: begin
        if (!bus.cyc) begin
          w_state_nxt = IDLE;
        end else if (bus.stb) begin
          if (bus.we) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ack      = 1'b1;
            w_advance  = 1'b1;
            w_mem_re   = 1'b1;
            w_mem_addr = w_next[MEM_ADR_WIDTH-1:0];
            if (bus.cti == CTI_EOB || bus.cti == CTI_CLASSIC) begin
              w_state_nxt = IDLE;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (!rst) begin
      w_ack     = 1'b0;
      w_err     = 1'b0;
      w_mem_re  = 1'b0;
      w_mem_we  = '0;
      w_capture = 1'b0;
      w_advance = 1'b0;
    end
  end

  bram_sp #(
    .MEM_ADR_WIDTH (MEM_ADR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .re    (w_mem_re),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (bus.dat_ms),
    .rdata (w_rdata)
  );

  assign bus.dat_sm = w_rdata;
  assign bus.ack    = w_ack;
  assign bus.err    = w_err;
  assign bus.rty    = 1'b0;

endmodule

`default_nettype wire
